// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the hardwired ALU control sequencer:
// FSM states, opcode encodings, IR field positions and instruction classes.
package alu_seq_pkg;

  localparam int OPC_BITS   = 5;
  localparam int IR_OPC_LSB = 27;
  localparam int IR_RA_LSB  = 23;
  localparam int IR_RB_LSB  = 19;
  localparam int IR_RC_LSB  = 15;

  typedef logic [OPC_BITS-1:0] opcode_t;

  localparam opcode_t OP_ADD  = 5'b00011;
  localparam opcode_t OP_SUB  = 5'b00100;
  localparam opcode_t OP_AND  = 5'b00101;
  localparam opcode_t OP_OR   = 5'b00110;
  localparam opcode_t OP_SHR  = 5'b00111;
  localparam opcode_t OP_SHL  = 5'b01001;
  localparam opcode_t OP_ROR  = 5'b01010;
  localparam opcode_t OP_ROL  = 5'b01011;
  localparam opcode_t OP_MUL  = 5'b01111;
  localparam opcode_t OP_DIV  = 5'b10000;
  localparam opcode_t OP_NEG  = 5'b10001;
  localparam opcode_t OP_NOT  = 5'b10010;
  localparam opcode_t OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_e;

  typedef enum logic [1:0] {
    CLS_BIN, CLS_UNARY, CLS_MULDIV, CLS_HALT
  } seq_class_e;

endpackage

// File: rtl/alu_seq_decode.sv
// Purely combinational IR decode: instruction class plus one-hot Ra/Rb/Rc
// selects (register fields taken modulo NUM_REGS).
module alu_seq_decode
  import alu_seq_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int REG_W    = 4
) (
  input  logic [31:0]         ir,
  output seq_class_e          cls,
  output logic [NUM_REGS-1:0] ra_oh,
  output logic [NUM_REGS-1:0] rb_oh,
  output logic [NUM_REGS-1:0] rc_oh
);

  opcode_t          opc;
  logic [REG_W-1:0] ra, rb, rc;
  logic             unused_ir;

  assign opc = ir[IR_OPC_LSB +: OPC_BITS];
  assign ra  = ir[IR_RA_LSB +: REG_W];
  assign rb  = ir[IR_RB_LSB +: REG_W];
  assign rc  = ir[IR_RC_LSB +: REG_W];
  // Immediate/low IR bits carry no meaning for the sequencer.
  assign unused_ir = ^ir[IR_RC_LSB-1:0];

  function automatic logic [NUM_REGS-1:0] to_onehot(input logic [REG_W-1:0] f);
    return NUM_REGS'(1) << (int'(f) % NUM_REGS);
  endfunction

  assign ra_oh = to_onehot(ra);
  assign rb_oh = to_onehot(rb);
  assign rc_oh = to_onehot(rc);

  always_comb begin
    cls = CLS_HALT;
    case (opc)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_SHR, OP_SHL, OP_ROR, OP_ROL: cls = CLS_BIN;
      OP_NEG, OP_NOT:                 cls = CLS_UNARY;
      OP_MUL, OP_DIV:                 cls = CLS_MULDIV;
      OP_HALT:                        cls = CLS_HALT;
      default:                        cls = CLS_HALT;
    endcase
  end

endmodule

// File: rtl/alu_control_sequencer.sv
// Hardwired fetch/execute control unit driving datapath strobes.
// Optional ALU_SEQ_INSTR_CNT_EN adds a 32-bit completed-instruction counter.
module alu_control_sequencer
  import alu_seq_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int OPC_W    = 5,
  parameter int REG_W    = 4
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                run,
  input  logic [31:0]         IR,
  output logic [NUM_REGS-1:0] Rin,
  output logic [NUM_REGS-1:0] Rout,
  output logic                PCout,
  output logic                PCin,
  output logic                IncPC,
  output logic                MARin,
  output logic                Read,
  output logic                MDRin,
  output logic                MDRout,
  output logic                IRin,
  output logic                Yin,
  output logic                Zin,
  output logic                ZLOout,
  output logic                ZHIout,
  output logic                HIin,
  output logic                LOin,
  output logic [OPC_W-1:0]    ALU_opcode,
  output logic                busy,
  output logic                halted
`ifdef ALU_SEQ_INSTR_CNT_EN
  , output logic [31:0]       instr_count
`endif
);

  state_e              state_q, state_d;
  seq_class_e          cls;
  logic [NUM_REGS-1:0] ra_oh, rb_oh, rc_oh;
  logic [OPC_W-1:0]    opcode;
  state_e              after_instr;

  assign opcode      = IR[IR_OPC_LSB +: OPC_W];
  assign after_instr = run ? S_T0 : S_IDLE;

  alu_seq_decode #(
    .NUM_REGS (NUM_REGS),
    .REG_W    (REG_W)
  ) u_decode (
    .ir    (IR),
    .cls   (cls),
    .ra_oh (ra_oh),
    .rb_oh (rb_oh),
    .rc_oh (rc_oh)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; clr is asynchronous so outputs drop without waiting for clk.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = run ? S_T0 : S_IDLE;
      S_T0:   state_d = S_T1;
      S_T1:   state_d = S_T2;
      S_T2:   state_d = S_T3;
      S_T3:   state_d = (cls == CLS_HALT) ? S_HALT : S_T4;
      S_T4:   state_d = (cls == CLS_UNARY) ? after_instr : S_T5;
      S_T5: begin
        case (cls)
          CLS_BIN:    state_d = after_instr;
          CLS_MULDIV: state_d = S_T6;
          default:    state_d = S_IDLE;
        endcase
      end
      S_T6:   state_d = after_instr;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: every output gets a default before the case so no latch is inferred
  // and nothing stays high outside the states that name it.
  always_comb begin
    Rin        = '0;
    Rout       = '0;
    PCout      = 1'b0;
    PCin       = 1'b0;
    IncPC      = 1'b0;
    MARin      = 1'b0;
    Read       = 1'b0;
    MDRin      = 1'b0;
    MDRout     = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    Zin        = 1'b0;
    ZLOout     = 1'b0;
    ZHIout     = 1'b0;
    HIin       = 1'b0;
    LOin       = 1'b0;
    ALU_opcode = '0;
    busy       = (state_q != S_IDLE) && (state_q != S_HALT);
    halted     = (state_q == S_HALT);
    case (state_q)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      S_T1: begin ZLOout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        if (cls == CLS_UNARY) begin
          Rout = rb_oh; ALU_opcode = opcode; Zin = 1'b1;
        end else if (cls != CLS_HALT) begin
          Rout = rb_oh; Yin = 1'b1;
        end
      end
      S_T4: begin
        if (cls == CLS_UNARY) begin
          ZLOout = 1'b1; Rin = ra_oh;
        end else begin
          Rout = rc_oh; ALU_opcode = opcode; Zin = 1'b1;
        end
      end
      S_T5: begin
        if (cls == CLS_BIN) begin
          ZLOout = 1'b1; Rin = ra_oh;
        end else if (cls == CLS_MULDIV) begin
          ZLOout = 1'b1; LOin = 1'b1;
        end
      end
      S_T6: begin ZHIout = 1'b1; HIin = 1'b1; end
      default: ;
    endcase
  end

`ifdef ALU_SEQ_INSTR_CNT_EN
  // An instruction completes when its last execute state is left; HALT never counts.
  logic instr_last;
  assign instr_last = ((state_q == S_T4) && (cls == CLS_UNARY)) ||
                      ((state_q == S_T5) && (cls == CLS_BIN)) ||
                      (state_q == S_T6);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr)            instr_count <= '0;
    else if (instr_last) instr_count <= instr_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Directed scoreboard bench for alu_control_sequencer; expected per-cycle
// outputs are queued as each instruction is issued and checked on negedges.
`timescale 1ns/1ps
module tb_alu_control_sequencer;

  logic        clk = 1'b0;
  logic        clr, run;
  logic [31:0] IR;
  logic [15:0] Rin, Rout;
  logic        PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin;
  logic        Yin, Zin, ZLOout, ZHIout, HIin, LOin;
  logic [4:0]  ALU_opcode;
  logic        busy, halted;
`ifdef ALU_SEQ_INSTR_CNT_EN
  logic [31:0] instr_count;
`endif

  alu_control_sequencer dut (
    .clk(clk), .clr(clr), .run(run), .IR(IR), .Rin(Rin), .Rout(Rout),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
    .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
    .Yin(Yin), .Zin(Zin), .ZLOout(ZLOout), .ZHIout(ZHIout),
    .HIin(HIin), .LOin(LOin), .ALU_opcode(ALU_opcode),
    .busy(busy), .halted(halted)
`ifdef ALU_SEQ_INSTR_CNT_EN
    , .instr_count(instr_count)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [13:0] M_PCOUT  = 14'd1 << 13;
  localparam logic [13:0] M_PCIN   = 14'd1 << 12;
  localparam logic [13:0] M_INCPC  = 14'd1 << 11;
  localparam logic [13:0] M_MARIN  = 14'd1 << 10;
  localparam logic [13:0] M_READ   = 14'd1 << 9;
  localparam logic [13:0] M_MDRIN  = 14'd1 << 8;
  localparam logic [13:0] M_MDROUT = 14'd1 << 7;
  localparam logic [13:0] M_IRIN   = 14'd1 << 6;
  localparam logic [13:0] M_YIN    = 14'd1 << 5;
  localparam logic [13:0] M_ZIN    = 14'd1 << 4;
  localparam logic [13:0] M_ZLOOUT = 14'd1 << 3;
  localparam logic [13:0] M_ZHIOUT = 14'd1 << 2;
  localparam logic [13:0] M_HIIN   = 14'd1 << 1;
  localparam logic [13:0] M_LOIN   = 14'd1 << 0;

  logic [13:0] stb_obs;
  assign stb_obs = {PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin,
                    Yin, Zin, ZLOout, ZHIout, HIin, LOin};

  typedef struct {
    string       tag;
    logic [13:0] stb;
    logic [15:0] rin;
    logic [15:0] rout;
    logic [4:0]  opc;
    logic        busy;
    logic        halted;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          tests  = 0;
  int          failed = 0;
  logic [31:0] model_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [13:0] stb, input logic [15:0] rin,
                      input logic [15:0] rout, input logic [4:0] opc,
                      input logic bsy, input logic hlt);
    exp_t e;
    e.tag = tag; e.stb = stb; e.rin = rin; e.rout = rout; e.opc = opc;
    e.busy = bsy; e.halted = hlt; e.cnt = model_cnt;
    sb.push_back(e);
  endtask

  task automatic check_now();
    exp_t e;
    if (sb.size() == 0) begin
      tests++; failed++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      check({e.tag, ".stb"},  32'(stb_obs),    32'(e.stb));
      check({e.tag, ".rin"},  32'(Rin),        32'(e.rin));
      check({e.tag, ".rout"}, 32'(Rout),       32'(e.rout));
      check({e.tag, ".opc"},  32'(ALU_opcode), 32'(e.opc));
      check({e.tag, ".busy_halted"}, 32'({busy, halted}), 32'({e.busy, e.halted}));
`ifdef ALU_SEQ_INSTR_CNT_EN
      check({e.tag, ".cnt"}, instr_count, e.cnt);
`endif
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_now();
    end
  endtask

  task automatic push_fetch(input string name);
    push({name, ".T0"}, M_PCOUT | M_MARIN | M_INCPC | M_ZIN, '0, '0, '0, 1'b1, 1'b0);
    push({name, ".T1"}, M_ZLOOUT | M_PCIN | M_READ | M_MDRIN, '0, '0, '0, 1'b1, 1'b0);
    push({name, ".T2"}, M_MDROUT | M_IRIN, '0, '0, '0, 1'b1, 1'b0);
  endtask

  // Issue one instruction: queue its expected cycles, load IR once fetch has
  // started, optionally drop run after the check of cycle index drop_at.
  task automatic instr(input string name, input logic [31:0] ir_v, input int drop_at);
    logic [4:0]  opc;
    logic [15:0] ra, rb, rc;
    int          n;
    opc = ir_v[31:27];
    ra  = 16'd1 << ir_v[26:23];
    rb  = 16'd1 << ir_v[22:19];
    rc  = 16'd1 << ir_v[18:15];
    push_fetch(name);
    case (opc)
      5'b00011, 5'b00100, 5'b00101, 5'b00110,
      5'b00111, 5'b01001, 5'b01010, 5'b01011: begin
        push({name, ".T3"}, M_YIN,    '0, rb, '0,  1'b1, 1'b0);
        push({name, ".T4"}, M_ZIN,    '0, rc, opc, 1'b1, 1'b0);
        push({name, ".T5"}, M_ZLOOUT, ra, '0, '0,  1'b1, 1'b0);
        model_cnt++;
      end
      5'b10001, 5'b10010: begin
        push({name, ".T3"}, M_ZIN,    '0, rb, opc, 1'b1, 1'b0);
        push({name, ".T4"}, M_ZLOOUT, ra, '0, '0,  1'b1, 1'b0);
        model_cnt++;
      end
      5'b01111, 5'b10000: begin
        push({name, ".T3"}, M_YIN,            '0, rb, '0,  1'b1, 1'b0);
        push({name, ".T4"}, M_ZIN,            '0, rc, opc, 1'b1, 1'b0);
        push({name, ".T5"}, M_ZLOOUT | M_LOIN, '0, '0, '0, 1'b1, 1'b0);
        push({name, ".T6"}, M_ZHIOUT | M_HIIN, '0, '0, '0, 1'b1, 1'b0);
        model_cnt++;
      end
      default: push({name, ".T3"}, '0, '0, '0, '0, 1'b1, 1'b0);
    endcase
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_now();
      if (i == 0) IR = ir_v;
      if (i == drop_at) run = 1'b0;
    end
  endtask

  initial begin
    clr = 1'b0; run = 1'b1; IR = '0; model_cnt = '0;

    // Held in reset with run high: everything stays low.
    push("reset", '0, '0, '0, '0, 1'b0, 1'b0);
    push("reset_hold", '0, '0, '0, '0, 1'b0, 1'b0);
    step(2);
    clr = 1'b1;

    // Back-to-back with run held high.
    instr("add_r1_r2_r3", 32'h18918000, -1);
    instr("not_r1_r6",    32'h90B00000, -1);
    instr("mul_r3_r4",    32'h781A0000, -1);
    // run dropped during T4: instruction completes, then IDLE.
    instr("add_drop",     32'h18918000, 4);
    push("idle_after_drop0", '0, '0, '0, '0, 1'b0, 1'b0);
    push("idle_after_drop1", '0, '0, '0, '0, 1'b0, 1'b0);
    step(2);

    // Register-field extremes (R15/R0) with junk in the low IR bits.
    run = 1'b1;
    instr("sub_r15_r0_r15", {5'b00100, 4'd15, 4'd0, 4'd15, 15'h7FFF}, -1);
    instr("div_r0_r9",      {5'b10000, 4'd0, 4'd0, 4'd9, 15'h1234}, -1);
    instr("neg_r0_r7",      {5'b10001, 4'd0, 4'd7, 4'd0, 15'h0000}, 4);
    push("idle_after_neg", '0, '0, '0, '0, 1'b0, 1'b0);
    step(1);

    // HALT is sticky regardless of run.
    run = 1'b1;
    instr("halt", 32'hD8000000, -1);
    for (int i = 0; i < 4; i++) begin
      push("halt_sticky", '0, '0, '0, '0, 1'b0, 1'b1);
      step(1);
      run = ~run;
    end

    // clr clears HALT immediately.
    clr = 1'b0;
    model_cnt = '0;
    #1;
    push("clr_from_halt", '0, '0, '0, '0, 1'b0, 1'b0);
    check_now();
    step(0);
    push("clr_from_halt_hold", '0, '0, '0, '0, 1'b0, 1'b0);
    step(1);
    clr = 1'b1; run = 1'b1;

    // Unsupported opcode behaves like HALT.
    instr("unknown_11111", 32'hF8000000, -1);
    push("unknown_halted0", '0, '0, '0, '0, 1'b0, 1'b1);
    push("unknown_halted1", '0, '0, '0, '0, 1'b0, 1'b1);
    step(2);

    // clr mid-instruction drops every strobe in the same cycle.
    clr = 1'b0;
    model_cnt = '0;
    #1;
    push("clr_unknown", '0, '0, '0, '0, 1'b0, 1'b0);
    check_now();
    @(negedge clk);
    clr = 1'b1; run = 1'b1; IR = 32'h18918000;
    push_fetch("abort_add");
    step(3);
    clr = 1'b0;
    #1;
    push("clr_mid_instr", '0, '0, '0, '0, 1'b0, 1'b0);
    check_now();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
